// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - control handshake and SPI pin bundle for spi_master
interface spi_master_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  sclk;
    logic                  ss;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start,
        input  tx_data,
        input  miso,
        output ready,
        output busy,
        output done,
        output rx_data,
        output sclk,
        output ss,
        output mosi
    );

    modport slave (
        output start,
        output tx_data,
        output miso,
        input  ready,
        input  busy,
        input  done,
        input  rx_data,
        input  sclk,
        input  ss,
        input  mosi
    );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, MSB-first frames with start/ready handshake
module spi_master #(
    parameter int DATA_WIDTH = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  phase_end;
    logic                  in_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.start) begin
                    tx_d    = bus.tx_data;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (phase_end) begin
                    div_d   = '0;
                    state_d = SCLK_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            SCLK_HI: begin
                // miso is captured in the same cycle sclk is first driven high
                if (div_q == '0) begin
                    rx_d = (rx_q << 1) | DATA_WIDTH'(bus.miso);
                end
                if (phase_end) begin
                    div_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        // mosi advances on the same edge that drops sclk
                        tx_d    = tx_q << 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = SCLK_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            SCLK_LO: begin
                if (phase_end) begin
                    div_d   = '0;
                    state_d = SCLK_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HOLD: begin
                if (phase_end) begin
                    div_d     = '0;
                    rx_data_d = rx_q;
                    state_d   = DONE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            DONE: begin
                div_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                div_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign in_frame = (state_q == SETUP) || (state_q == SCLK_HI) ||
                      (state_q == SCLK_LO) || (state_q == HOLD);

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.sclk    = (state_q == SCLK_HI);
    assign bus.ss      = ~in_frame;
    assign bus.mosi    = in_frame ? tx_q[DATA_WIDTH-1] : 1'b0;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master at CLK_DIV=2 and CLK_DIV=1
module tb_spi_master;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_WIDTH(W)) sif0 ();
    spi_master_if #(.DATA_WIDTH(W)) sif1 ();

    spi_master #(.DATA_WIDTH(W), .CLK_DIV(2)) u_dut0 (.clk(clk), .rst(rst), .bus(sif0));
    spi_master #(.DATA_WIDTH(W), .CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(sif1));

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] sw;
        logic [W-1:0] exp_rx;
        int unsigned  exp_low;
    } vec_t;

    int errors = 0;
    int checks = 0;

    int unsigned  low_cnt[2], last_low[2], high_cnt[2], last_high[2];
    int unsigned  rises[2], falls[2], frames[2], done_cnt[2];
    logic         prev_sclk[2], prev_ss[2];
    logic [W-1:0] mosi_seen[2], slave_word[2], last_rx[2];
    bit           loopback[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: slave word (or echoed tx) arrives intact, ss low for the whole frame.
    function automatic vec_t model(input logic [W-1:0] tx, input logic [W-1:0] sw,
                                   input bit lb, input int unsigned div);
        vec_t v;
        v.tx      = tx;
        v.sw      = sw;
        v.exp_rx  = lb ? tx : sw;
        v.exp_low = div * (2 * W + 1);
        return v;
    endfunction

    task automatic drive(input int d, input logic st, input logic [W-1:0] tx);
        if (d == 0) begin
            sif0.start   = st;
            sif0.tx_data = tx;
        end else begin
            sif1.start   = st;
            sif1.tx_data = tx;
        end
    endtask

    task automatic tick();
        logic         s[2], sv[2], m[2], dn[2], mi[2];
        logic [W-1:0] rxv[2];
        @(negedge clk);
        s[0] = sif0.sclk; sv[0] = sif0.ss; m[0] = sif0.mosi; dn[0] = sif0.done; rxv[0] = sif0.rx_data;
        s[1] = sif1.sclk; sv[1] = sif1.ss; m[1] = sif1.mosi; dn[1] = sif1.done; rxv[1] = sif1.rx_data;
        for (int d = 0; d < 2; d++) begin
            if (prev_ss[d] && !sv[d]) begin
                frames[d]++;
                last_high[d] = high_cnt[d];
                low_cnt[d]   = 0;
                rises[d]     = 0;
                falls[d]     = 0;
                mosi_seen[d] = '0;
            end
            if (!prev_ss[d] && sv[d]) begin
                last_low[d] = low_cnt[d];
                high_cnt[d] = 0;
            end
            if (sv[d]) high_cnt[d]++;
            else       low_cnt[d]++;
            if (!prev_sclk[d] && s[d]) begin
                rises[d]++;
                mosi_seen[d] = {mosi_seen[d][W-2:0], m[d]};
            end
            if (prev_sclk[d] && !s[d]) falls[d]++;
            if (dn[d]) begin
                done_cnt[d]++;
                last_rx[d] = rxv[d];
            end
            if (loopback[d])                  mi[d] = m[d];
            else if (!sv[d] && falls[d] < W)  mi[d] = slave_word[d][W-1-falls[d]];
            else                              mi[d] = 1'b0;
            prev_sclk[d] = s[d];
            prev_ss[d]   = sv[d];
        end
        sif0.miso = mi[0];
        sif1.miso = mi[1];
    endtask

    task automatic run_frame(input int d, input vec_t v, input bit lb, input string tag);
        int unsigned d0, f0;
        int          k;
        slave_word[d] = v.sw;
        loopback[d]   = lb;
        d0 = done_cnt[d];
        f0 = frames[d];
        drive(d, 1'b1, v.tx);
        tick();
        drive(d, 1'b0, W'($urandom));
        k = 0;
        while (done_cnt[d] == d0 && k < 200) begin
            tick();
            k++;
        end
        for (int i = 0; i < 3; i++) tick();
        check({tag, "_done_pulses"}, done_cnt[d] - d0, 1);
        check({tag, "_frames"}, frames[d] - f0, 1);
        check({tag, "_rx_done"}, 32'(last_rx[d]), 32'(v.exp_rx));
        check({tag, "_rx_held"}, 32'((d == 0) ? sif0.rx_data : sif1.rx_data), 32'(v.exp_rx));
        check({tag, "_mosi_bits"}, 32'(mosi_seen[d]), 32'(v.tx));
        check({tag, "_ss_low"}, last_low[d], v.exp_low);
        check({tag, "_sclk_rises"}, rises[d], W);
    endtask

    vec_t         tbl[8];
    logic [W-1:0] txs[3], sws[3];

    initial begin
        int unsigned d0, f0, seen, idx;
        int          k;
        logic        st;
        for (int d = 0; d < 2; d++) begin
            low_cnt[d] = 0; last_low[d] = 0; high_cnt[d] = 0; last_high[d] = 0;
            rises[d] = 0; falls[d] = 0; frames[d] = 0; done_cnt[d] = 0;
            prev_sclk[d] = 1'b0; prev_ss[d] = 1'b1;
            mosi_seen[d] = '0; slave_word[d] = '0; last_rx[d] = '0; loopback[d] = 1'b0;
        end
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        sif0.miso = 1'b0;
        sif1.miso = 1'b0;

        // Reset then idle
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_dut0", 32'({sif0.ready, sif0.busy, sif0.done, sif0.sclk, sif0.ss, sif0.mosi, sif0.rx_data}),
                  32'(10'b1000100000));
            check("idle_dut1", 32'({sif1.ready, sif1.busy, sif1.done, sif1.sclk, sif1.ss, sif1.mosi, sif1.rx_data}),
                  32'(10'b1000100000));
        end

        // Table of frames at CLK_DIV=2
        tbl[0] = model(4'b1011, 4'b0110, 1'b0, 2);
        tbl[1] = model(4'b0000, 4'b1111, 1'b0, 2);
        tbl[2] = model(4'b1111, 4'b0000, 1'b0, 2);
        for (int i = 3; i < 8; i++) tbl[i] = model(W'($urandom), W'($urandom), 1'b0, 2);
        for (int i = 0; i < 8; i++) run_frame(0, tbl[i], 1'b0, "tbl");

        // Loopback at CLK_DIV=1, every word
        for (int t = 0; t < 16; t++) run_frame(1, model(W'(t), '0, 1'b1, 1), 1'b1, "loop");
        loopback[1] = 1'b0;

        // Start ignored while busy, including in DONE
        slave_word[0] = 4'b0110;
        d0 = done_cnt[0];
        f0 = frames[0];
        drive(0, 1'b1, 4'b1011);
        tick();
        for (int c = 1; c <= 60; c++) begin
            st = (c == 5) || (c == 17) || sif0.done;
            drive(0, st, W'($urandom));
            tick();
        end
        drive(0, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick();
        check("busy_done_pulses", done_cnt[0] - d0, 1);
        check("busy_frames", frames[0] - f0, 1);
        check("busy_mosi_bits", 32'(mosi_seen[0]), 32'(4'b1011));
        check("busy_rx", 32'(last_rx[0]), 32'(4'b0110));

        // Back-to-back with start held high
        for (int i = 0; i < 3; i++) begin
            txs[i] = W'($urandom);
            sws[i] = W'($urandom);
        end
        d0 = done_cnt[0];
        f0 = frames[0];
        seen = 0;
        slave_word[0] = sws[0];
        drive(0, 1'b1, txs[0]);
        k = 0;
        while (done_cnt[0] - d0 < 3 && k < 300) begin
            tick();
            k++;
            if (frames[0] - f0 > seen) begin
                seen++;
                if (seen > 1) check("b2b_ss_gap", last_high[0], 2);
            end
            if (sif0.done) begin
                idx = done_cnt[0] - d0;
                check("b2b_rx", 32'(last_rx[0]), 32'(sws[idx-1]));
                check("b2b_mosi_bits", 32'(mosi_seen[0]), 32'(txs[idx-1]));
                if (idx < 3) begin
                    slave_word[0] = sws[idx];
                    drive(0, 1'b1, txs[idx]);
                end else begin
                    drive(0, 1'b0, '0);
                end
            end
        end
        drive(0, 1'b0, '0);
        for (int i = 0; i < 10; i++) tick();
        check("b2b_done_pulses", done_cnt[0] - d0, 3);
        check("b2b_frames", frames[0] - f0, 3);

        // Reset after the 2nd sclk rising edge
        slave_word[0] = 4'b1001;
        d0 = done_cnt[0];
        drive(0, 1'b1, 4'b0111);
        tick();
        drive(0, 1'b0, '0);
        k = 0;
        while (rises[0] < 2 && k < 100) begin
            tick();
            k++;
        end
        check("rst_reached_2nd_rise", rises[0], 2);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'({sif0.ss, sif0.sclk, sif0.done, sif0.ready, sif0.busy, sif0.rx_data}),
              32'(9'b100100000));
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_no_done", done_cnt[0] - d0, 0);
        check("rst_rx_zero", 32'(sif0.rx_data), 0);
        run_frame(0, model(4'b1101, 4'b0101, 1'b0, 2), 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Upstream SPI master that sends 4-bit words to the slave stage, which drives the 7-segment display and the PWM.
- Accepts a word from local control logic over a start/ready handshake and serialises it MSB-first on mosi.
- Generates sclk and the frame select.
- Captures miso in parallel and returns the received word with a one-cycle done strobe.

Parameters:
- DATA_WIDTH, 4, bits per frame; must be 1 or more.
- CLK_DIV, 2, clk cycles per sclk half-period; must be 1 or more.

Ports:
- clk  input  1  system clock; every register is updated on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to send tx_data; sampled only while ready=1.
- tx_data  input  DATA_WIDTH  word to send; latched in the cycle start is accepted.
- ready  output  1  high only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a frame completes.
- rx_data  output  DATA_WIDTH  word captured from miso; updated in the done cycle and held afterwards.
- sclk  output  1  serial clock; idles low.
- ss  output  1  frame select, active-low; idles high.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- Reset values, applied immediately while rst=1:
  - state=IDLE, ready=1, busy=0, done=0, rx_data=0.
  - sclk=0, ss=1, mosi=0.
  - tx shift register, rx shift register, bit counter and divider counter all 0.
- Reset asserted mid-frame aborts the frame: no done pulse, rx_data stays 0, ss goes high without waiting for a clock edge.
- SPI mode 0:
  - mosi changes only while sclk is low.
  - The slave samples mosi on the sclk rising edge.
  - The master samples miso in the clk cycle in which it drives sclk high.
- States: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, DONE.
- IDLE:
  - ready=1, sclk=0, ss=1.
  - start=1 latches tx_data and moves to SETUP on the next edge.
- SETUP, CLK_DIV cycles:
  - ss=0, sclk=0, mosi = tx_data[DATA_WIDTH-1].
  - Then go to SCLK_HI.
- SCLK_HI, CLK_DIV cycles:
  - sclk=1, mosi held.
  - On the entry cycle, miso shifts into the rx register LSB; the rx register shifts left.
  - If the bit counter equals DATA_WIDTH-1, go to HOLD; otherwise go to SCLK_LO.
- SCLK_LO, CLK_DIV cycles:
  - sclk=0.
  - On the entry cycle, mosi advances to the next lower bit and the bit counter increments.
  - Then go to SCLK_HI.
- HOLD, CLK_DIV cycles:
  - sclk=0, ss=0, mosi held.
  - Then go to DONE.
- DONE, 1 cycle:
  - ss=1, done=1, rx_data = rx register, ready=0.
  - Then go to IDLE.
- Timing:
  - ss is low for exactly CLK_DIV*(2*DATA_WIDTH+1) cycles; 18 cycles at the defaults.
  - sclk produces exactly DATA_WIDTH rising edges per frame.
- Handshake:
  - start while ready=0 (any non-IDLE state, including DONE) is ignored and is not queued.
  - tx_data may change freely after acceptance.
- Back-to-back frames: start held high gives ss high for exactly 2 cycles between frames (DONE plus IDLE).
- CLK_DIV=1: each phase lasts 1 cycle and sclk toggles every clk cycle.
- Divider counter: counts 0 to CLK_DIV-1, wraps to 0 on each phase change, and is never left non-zero in IDLE.
- Width rules:
  - bit counter is $clog2(DATA_WIDTH)+1 bits; divider counter is $clog2(CLK_DIV)+1 bits.
  - No truncation warnings are permitted.

Test Plan:
- Reset then idle: hold rst for 3 cycles, release, wait 20 cycles -> ready=1, busy=0, sclk=0, ss=1, mosi=0, done=0, rx_data=0 throughout.
- Single frame at defaults: tx_data=4'b1011 with start for 1 cycle, miso driven by a model returning 4'b0110 on sclk rising edges ->
  - mosi sampled at sclk rises reads 1,0,1,1;
  - ss low for 18 cycles with 4 sclk rising edges;
  - done pulses once;
  - rx_data=4'b0110.
- Loopback (miso tied to mosi), CLK_DIV=1, all 16 values of tx_data -> rx_data equals tx_data each time; ss low for 9 cycles per frame.
- Start ignored while busy: pulse start at cycles 5 and 17 of a frame and in the DONE cycle -> exactly one frame and one done pulse; tx_data latched at acceptance is unchanged.
- Back-to-back: start held high for 3 frames -> 3 done pulses; ss high for exactly 2 cycles between frames.
- Reset mid-frame: assert rst after the 2nd sclk rising edge ->
  - in the same cycle, ss=1, sclk=0, done=0, rx_data=0;
  - after release, the next frame is bit-exact.
